// File: rtl/rr_core_scheduler.sv
// Round-robin job dispatcher for N_CORES compute cores with tagged, round-robin result return.
// Each core slot tracks IDLE/RUN/HOLD; grants and result selection rotate from the last served core.
module rr_core_scheduler #(
    parameter int N_CORES = 4,
    parameter int JOB_W   = 64,
    parameter int RES_W   = 64,
    parameter int TAG_W   = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     enable,
    input  logic [N_CORES-1:0]       core_mask,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [JOB_W-1:0]         job_data,
    input  logic [TAG_W-1:0]         job_tag,
    output logic [N_CORES-1:0]       core_start,
    output logic [JOB_W-1:0]         core_data,
    input  logic [N_CORES-1:0]       core_busy,
    input  logic [N_CORES-1:0]       core_done,
    input  logic [N_CORES*RES_W-1:0] core_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic [2:0]               res_core,
    output logic [31:0]              jobs_issued,
    output logic [31:0]              jobs_done,
    output logic                     idle,
    output logic                     err_spurious
);
    localparam int IW = $clog2(N_CORES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} cstate_t;

    cstate_t           state [N_CORES];
    logic [TAG_W-1:0]  tag_q [N_CORES];
    logic [RES_W-1:0]  res_q [N_CORES];
    logic [IW-1:0]     dptr, optr, gsel, ssel, osel, lsel, gidx, oidx;
    logic              gfound, sfound, lock;
    logic [N_CORES-1:0] elig, hold;
    logic              job_acc, res_hs;

    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            elig[i] = (state[i] == S_IDLE) && core_mask[i] && !core_busy[i];
            hold[i] = (state[i] == S_HOLD);
        end
    end

    // Both searches start just past the last served core so service rotates.
    always_comb begin
        gfound = 1'b0;
        gsel   = '0;
        sfound = 1'b0;
        ssel   = '0;
        gidx   = '0;
        oidx   = '0;
        for (int k = 0; k < N_CORES; k++) begin
            gidx = IW'((int'(dptr) + 1 + k) % N_CORES);
            oidx = IW'((int'(optr) + 1 + k) % N_CORES);
            if (!gfound && elig[gidx]) begin
                gfound = 1'b1;
                gsel   = gidx;
            end
            if (!sfound && hold[oidx]) begin
                sfound = 1'b1;
                ssel   = oidx;
            end
        end
    end

    assign job_ready = enable && gfound;
    assign job_acc   = job_valid && job_ready;

    // A stalled result keeps its selection so the presented beat never changes.
    assign osel      = lock ? lsel : ssel;
    assign res_valid = lock || sfound;
    assign res_hs    = res_valid && res_ready;
    assign res_data  = res_valid ? res_q[osel] : '0;
    assign res_tag   = res_valid ? tag_q[osel] : '0;
    assign res_core  = res_valid ? 3'(osel) : 3'd0;

    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < N_CORES; i++)
            if (state[i] != S_IDLE) idle = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < N_CORES; i++) begin
                state[i] <= S_IDLE;
                tag_q[i] <= '0;
                res_q[i] <= '0;
            end
            dptr         <= IW'(N_CORES - 1);
            optr         <= IW'(N_CORES - 1);
            lock         <= 1'b0;
            lsel         <= '0;
            core_start   <= '0;
            core_data    <= '0;
            jobs_issued  <= '0;
            jobs_done    <= '0;
            err_spurious <= 1'b0;
        end else begin
            core_start <= '0;
            if (job_acc) begin
                core_start  <= N_CORES'(1) << gsel;
                core_data   <= job_data;
                dptr        <= gsel;
                jobs_issued <= jobs_issued + 32'd1;
            end
            if (res_hs) begin
                optr      <= osel;
                jobs_done <= jobs_done + 32'd1;
            end
            lock <= res_valid && !res_ready;
            if (res_valid && !res_ready) lsel <= osel;

            // Grant, done and handshake touch disjoint states, so one core sees at most one.
            for (int i = 0; i < N_CORES; i++) begin
                if (job_acc && gsel == IW'(i)) begin
                    state[i] <= S_RUN;
                    tag_q[i] <= job_tag;
                end
                if (core_done[i]) begin
                    if (state[i] == S_RUN) begin
                        res_q[i] <= core_result[i*RES_W +: RES_W];
                        state[i] <= S_HOLD;
                    end else begin
                        err_spurious <= 1'b1;
                    end
                end
                if (res_hs && osel == IW'(i))
                    state[i] <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rr_core_scheduler.sv
// Directed bench: stimulus pushes expected starts/results; negedge monitors pop and compare.
module tb_rr_core_scheduler;
    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic         enable;
    logic [3:0]   core_mask;
    logic         job_valid;
    logic         job_ready;
    logic [63:0]  job_data;
    logic [7:0]   job_tag;
    logic [3:0]   core_start;
    logic [63:0]  core_data;
    logic [3:0]   core_busy;
    logic [3:0]   core_done;
    logic [255:0] core_result;
    logic         res_valid;
    logic         res_ready;
    logic [63:0]  res_data;
    logic [7:0]   res_tag;
    logic [2:0]   res_core;
    logic [31:0]  jobs_issued;
    logic [31:0]  jobs_done;
    logic         idle;
    logic         err_spurious;

    int checks = 0;
    int errors = 0;

    typedef struct {int core; logic [63:0] data;} st_t;
    typedef struct {logic [63:0] data; logic [7:0] tag; int core;} rt_t;
    st_t sq[$];
    rt_t rq[$];

    rr_core_scheduler dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .core_mask(core_mask),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data), .job_tag(job_tag),
        .core_start(core_start), .core_data(core_data), .core_busy(core_busy),
        .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .res_core(res_core), .jobs_issued(jobs_issued), .jobs_done(jobs_done),
        .idle(idle), .err_spurious(err_spurious)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [63:0] rv(input int c, input logic [7:0] t);
        return {48'hC0DE_0000_0000, 4'(c), 4'h0, t};
    endfunction

    function automatic logic [63:0] jd(input logic [7:0] t);
        return {32'hDA7A_0000, 24'h0, t};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_job(input logic [7:0] t, input int c);
        int n;
        sq.push_back('{c, jd(t)});
        job_valid = 1'b1;
        job_data  = jd(t);
        job_tag   = t;
        n = 0;
        while (n < 100) begin
            @(negedge ACLK);
            if (job_ready) break;
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL job_ready_timeout act=0 exp=1 tag=%h", t);
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic do_done(input int c, input logic [7:0] t);
        rq.push_back('{rv(c, t), t, c});
        core_done[c] = 1'b1;
        core_result[c*64 +: 64] = rv(c, t);
        tick();
        core_done = '0;
    endtask

    task automatic chk_reset_vals(input string tagname);
        chk({tagname, "_core_start"}, 64'(core_start), 64'd0);
        chk({tagname, "_core_data"}, core_data, 64'd0);
        chk({tagname, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tagname, "_res_data"}, res_data, 64'd0);
        chk({tagname, "_res_tag"}, 64'(res_tag), 64'd0);
        chk({tagname, "_res_core"}, 64'(res_core), 64'd0);
        chk({tagname, "_jobs_issued"}, 64'(jobs_issued), 64'd0);
        chk({tagname, "_jobs_done"}, 64'(jobs_done), 64'd0);
        chk({tagname, "_err_spurious"}, 64'(err_spurious), 64'd0);
        chk({tagname, "_idle"}, 64'(idle), 64'd1);
    endtask

    always @(negedge ACLK) begin
        if (ARESETN && core_start != 4'd0) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start act=%b exp=none", core_start);
            end else begin
                st_t e;
                e = sq.pop_front();
                chk("start_onehot", 64'(core_start), 64'(4'd1 << e.core));
                chk("start_data", core_data, e.data);
            end
        end
    end

    always @(negedge ACLK) begin
        if (ARESETN && res_valid && res_ready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result act=core%0d exp=none", res_core);
            end else begin
                rt_t e;
                e = rq.pop_front();
                chk("res_core", 64'(res_core), 64'(e.core));
                chk("res_tag", 64'(res_tag), 64'(e.tag));
                chk("res_data", res_data, e.data);
            end
        end
    end

    initial begin
        ARESETN = 1'b0; enable = 1'b0; core_mask = 4'h0; job_valid = 1'b0;
        job_data = '0; job_tag = '0; core_busy = '0; core_done = '0;
        core_result = '0; res_ready = 1'b0;
        tick(); tick();
        @(negedge ACLK);
        chk_reset_vals("rst");
        tick();
        ARESETN = 1'b1; enable = 1'b1; core_mask = 4'hF; res_ready = 1'b1;
        tick();

        // four back-to-back jobs to cores 0..3
        for (int i = 0; i < 4; i++) send_job(8'(8'h10 + i), i);
        @(negedge ACLK);
        chk("ready_all_busy", 64'(job_ready), 64'd0);
        chk("issued_4", 64'(jobs_issued), 64'd4);
        chk("not_idle", 64'(idle), 64'd0);
        tick();

        // completions 2,0,3,1 one per cycle drain in that order
        do_done(2, 8'h12); do_done(0, 8'h10); do_done(3, 8'h13); do_done(1, 8'h11);
        tick(); tick();
        @(negedge ACLK);
        chk("done_4", 64'(jobs_done), 64'd4);
        chk("idle_after_drain", 64'(idle), 64'd1);
        tick();

        // stalled consumer: core1 locked in front although core0 would win a fresh search
        res_ready = 1'b0;
        send_job(8'h20, 0); send_job(8'h21, 1);
        do_done(1, 8'h21); do_done(0, 8'h20);
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_core", 64'(res_core), 64'd1);
            chk("stall_tag", 64'(res_tag), 64'h21);
            chk("stall_data", res_data, rv(1, 8'h21));
            tick();
        end
        res_ready = 1'b1;
        tick(); tick();
        @(negedge ACLK);
        chk("stall_drained", 64'(res_valid), 64'd0);
        chk("done_6", 64'(jobs_done), 64'd6);
        tick();

        // masked to cores 0 and 2 only
        core_mask = 4'b0101;
        send_job(8'h30, 2); send_job(8'h31, 0);
        do_done(2, 8'h30); send_job(8'h32, 2);
        do_done(0, 8'h31); send_job(8'h33, 0);
        do_done(2, 8'h32); send_job(8'h34, 2);
        do_done(0, 8'h33); send_job(8'h35, 0);
        do_done(2, 8'h34); do_done(0, 8'h35);
        tick(); tick();
        @(negedge ACLK);
        chk("mask_issued", 64'(jobs_issued), 64'd12);
        chk("mask_done", 64'(jobs_done), 64'd12);
        chk("mask_idle", 64'(idle), 64'd1);
        tick();

        // spurious done on idle core 1
        core_mask = 4'hF;
        core_done[1] = 1'b1;
        core_result[64 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        core_done = '0;
        @(negedge ACLK);
        chk("spur_set", 64'(err_spurious), 64'd1);
        chk("spur_idle", 64'(idle), 64'd1);
        chk("spur_no_res", 64'(res_valid), 64'd0);
        tick();
        send_job(8'h40, 1);
        do_done(1, 8'h40);
        tick(); tick();
        @(negedge ACLK);
        chk("spur_sticky", 64'(err_spurious), 64'd1);
        chk("done_13", 64'(jobs_done), 64'd13);
        tick();

        // reset with two jobs in flight
        send_job(8'h50, 2); send_job(8'h51, 3);
        tick();
        ARESETN = 1'b0;
        #1;
        chk("async_idle", 64'(idle), 64'd1);
        chk("async_issued", 64'(jobs_issued), 64'd0);
        tick(); tick(); tick();
        @(negedge ACLK);
        chk_reset_vals("mid_rst");
        tick();
        ARESETN = 1'b1;
        tick();
        send_job(8'h60, 0);
        do_done(0, 8'h60);
        tick(); tick();
        @(negedge ACLK);
        chk("post_rst_issued", 64'(jobs_issued), 64'd1);
        chk("post_rst_done", 64'(jobs_done), 64'd1);

        for (int n = 0; n < 50 && (sq.size() != 0 || rq.size() != 0); n++) tick();
        chk("start_queue_empty", 64'(sq.size()), 64'd0);
        chk("res_queue_empty", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
